// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the EXU branch resolution slice.
// Op codes, link-register indices, reset level and the instruction address width.
package branch_resolve_unit_pkg;

  localparam int         INS_BUS_A = 32;
  localparam logic       RST_EN    = 1'b0;
  localparam logic [4:0] RA_X1     = 5'd1;
  localparam logic [4:0] RA_X5     = 5'd5;
  localparam logic [4:0] REG_X0    = 5'd0;

  typedef enum logic [3:0] {
    BR_OP_BEQ  = 4'h0,
    BR_OP_BNE  = 4'h1,
    BR_OP_BLT  = 4'h4,
    BR_OP_BGE  = 4'h5,
    BR_OP_BLTU = 4'h6,
    BR_OP_BGEU = 4'h7,
    BR_OP_JAL  = 4'h8,
    BR_OP_JALR = 4'h9
  } br_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } br_state_e;

  function automatic logic is_link_reg(input logic [4:0] idx);
    return (idx == RA_X1) || (idx == RA_X5);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_br_compare.sv
// Combinational branch condition evaluation and jump classification.
// Unknown op codes resolve as not-taken and non-jump.
module br_compare
  import branch_resolve_unit_pkg::*;
(
  input  logic [3:0]           i_op,
  input  logic [INS_BUS_A-1:0] i_rs1,
  input  logic [INS_BUS_A-1:0] i_rs2,
  output logic                 o_taken,
  output logic                 o_is_jal,
  output logic                 o_is_jalr
);

  always_comb begin
    o_taken   = 1'b0;
    o_is_jal  = 1'b0;
    o_is_jalr = 1'b0;
    case (i_op)
      BR_OP_BEQ:  o_taken = (i_rs1 == i_rs2);
      BR_OP_BNE:  o_taken = (i_rs1 != i_rs2);
      BR_OP_BLT:  o_taken = ($signed(i_rs1) <  $signed(i_rs2));
      BR_OP_BGE:  o_taken = ($signed(i_rs1) >= $signed(i_rs2));
      BR_OP_BLTU: o_taken = (i_rs1 <  i_rs2);
      BR_OP_BGEU: o_taken = (i_rs1 >= i_rs2);
      BR_OP_JAL: begin
        o_taken  = 1'b1;
        o_is_jal = 1'b1;
      end
      BR_OP_JALR: begin
        o_taken   = 1'b1;
        o_is_jalr = 1'b1;
      end
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EXU branch resolution: computes outcome/target, registers the update packet for the
// predictor, drives the IFU redirect and drains wrong-path ops for KILL_CYCLES after it.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int KILL_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 valid_i,
  input  logic [3:0]           op_i,
  input  logic [INS_BUS_A-1:0] pc_i,
  input  logic [INS_BUS_A-1:0] rs1_data_i,
  input  logic [INS_BUS_A-1:0] rs2_data_i,
  input  logic [INS_BUS_A-1:0] imm_i,
  input  logic [4:0]           rd_idx_i,
  input  logic [4:0]           rs1_idx_i,
  input  logic                 pred_taken_i,
  input  logic [INS_BUS_A-1:0] pred_next_pc_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic                 branch_request_o,
  output logic [INS_BUS_A-1:0] branch_source_o,
  output logic                 branch_is_taken_o,
  output logic                 branch_is_call_o,
  output logic                 branch_is_ret_o,
  output logic                 branch_is_jmp_o,
  output logic [INS_BUS_A-1:0] branch_target_o,
  output logic                 branch_mispredict_o,
  output logic                 redirect_o,
  output logic                 misalign_o,
  output logic [CNT_W-1:0]     br_cnt_o,
  output logic [CNT_W-1:0]     mispred_cnt_o
);

  localparam int            KW        = (KILL_CYCLES < 2) ? 1 : $clog2(KILL_CYCLES + 1);
  localparam logic [KW-1:0] KILL_LOAD = KW'(KILL_CYCLES);
  localparam logic [KW-1:0] KILL_ONE  = KW'(1);

  logic                 w_taken;
  logic                 w_is_jal;
  logic                 w_is_jalr;
  logic                 w_is_jump;
  logic [INS_BUS_A-1:0] w_target;
  logic [INS_BUS_A-1:0] w_seq_pc;
  logic [INS_BUS_A-1:0] w_actual_next;
  logic                 w_mispredict;
  logic                 w_misalign;
  logic                 w_call;
  logic                 w_ret;
  logic                 w_accept;
  logic                 w_unused;

  br_compare u_br_compare (
    .i_op      (op_i),
    .i_rs1     (rs1_data_i),
    .i_rs2     (rs2_data_i),
    .o_taken   (w_taken),
    .o_is_jal  (w_is_jal),
    .o_is_jalr (w_is_jalr)
  );

  // The IFU's taken bit is implied by pred_next_pc_i; only the PC is compared.
  assign w_unused      = pred_taken_i;

  assign w_is_jump     = w_is_jal | w_is_jalr;
  assign w_target      = w_is_jalr ? ((rs1_data_i + imm_i) & ~32'h1) : (pc_i + imm_i);
  assign w_seq_pc      = pc_i + 32'd4;
  assign w_actual_next = w_taken ? w_target : w_seq_pc;
  assign w_mispredict  = (w_actual_next != pred_next_pc_i);
  assign w_misalign    = w_taken & w_target[1];
  assign w_call        = w_is_jump & is_link_reg(rd_idx_i);
  assign w_ret         = w_is_jalr & is_link_reg(rs1_idx_i) & (rd_idx_i == REG_X0);

  br_state_e     r_state;
  logic [KW-1:0] r_kill_cnt;
  logic                 r_request;
  logic [INS_BUS_A-1:0] r_source;
  logic                 r_taken;
  logic                 r_call;
  logic                 r_ret;
  logic                 r_jmp;
  logic [INS_BUS_A-1:0] r_target;
  logic                 r_mispredict;
  logic                 r_redirect;
  logic                 r_misalign;
  logic [CNT_W-1:0]     r_br_cnt;
  logic [CNT_W-1:0]     r_mispred_cnt;

  assign w_accept = valid_i & ~stall_i & ~flush_i & (r_state == ST_RUN);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (n_rst_i == RST_EN) begin
      r_state       <= ST_RUN;
      r_kill_cnt    <= '0;
      r_request     <= 1'b0;
      r_source      <= '0;
      r_taken       <= 1'b0;
      r_call        <= 1'b0;
      r_ret         <= 1'b0;
      r_jmp         <= 1'b0;
      r_target      <= '0;
      r_mispredict  <= 1'b0;
      r_redirect    <= 1'b0;
      r_misalign    <= 1'b0;
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      // Flags are single-cycle pulses; source/target hold their last value.
      r_request    <= 1'b0;
      r_taken      <= 1'b0;
      r_call       <= 1'b0;
      r_ret        <= 1'b0;
      r_jmp        <= 1'b0;
      r_mispredict <= 1'b0;
      r_redirect   <= 1'b0;
      r_misalign   <= 1'b0;
      if (w_accept) begin
        if (w_misalign) begin
          r_misalign <= 1'b1;
        end else begin
          r_request    <= 1'b1;
          r_source     <= pc_i;
          r_taken      <= w_taken;
          r_call       <= w_call;
          r_ret        <= w_ret;
          r_jmp        <= w_is_jump & ~w_call & ~w_ret;
          r_target     <= w_actual_next;
          r_mispredict <= w_mispredict;
          r_redirect   <= w_mispredict;
          r_br_cnt     <= r_br_cnt + CNT_W'(1);
          if (w_mispredict) begin
            r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            if (KILL_CYCLES > 0) begin
              r_state    <= ST_KILL;
              r_kill_cnt <= KILL_LOAD;
            end
          end
        end
      end else if (r_state == ST_KILL) begin
        if (flush_i || (r_kill_cnt <= KILL_ONE)) begin
          r_state    <= ST_RUN;
          r_kill_cnt <= '0;
        end else begin
          r_kill_cnt <= r_kill_cnt - KILL_ONE;
        end
      end
    end
  end

  assign branch_request_o    = r_request;
  assign branch_source_o     = r_source;
  assign branch_is_taken_o   = r_taken;
  assign branch_is_call_o    = r_call;
  assign branch_is_ret_o     = r_ret;
  assign branch_is_jmp_o     = r_jmp;
  assign branch_target_o     = r_target;
  assign branch_mispredict_o = r_mispredict;
  assign redirect_o          = r_redirect;
  assign misalign_o          = r_misalign;
  assign br_cnt_o            = r_br_cnt;
  assign mispred_cnt_o       = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed vectors covering outcome,
// classification, KILL drain, misalign, flush, async reset and perf counters.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clk_i   = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        valid_i;
  logic [3:0]  op_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [4:0]  rd_idx_i;
  logic [4:0]  rs1_idx_i;
  logic        pred_taken_i;
  logic [31:0] pred_next_pc_i;
  logic        stall_i;
  logic        flush_i;
  logic        branch_request_o;
  logic [31:0] branch_source_o;
  logic        branch_is_taken_o;
  logic        branch_is_call_o;
  logic        branch_is_ret_o;
  logic        branch_is_jmp_o;
  logic [31:0] branch_target_o;
  logic        branch_mispredict_o;
  logic        redirect_o;
  logic        misalign_o;
  logic [31:0] br_cnt_o;
  logic [31:0] mispred_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  branch_resolve_unit #(.KILL_CYCLES(2), .CNT_W(32)) dut (
    .clk_i               (clk_i),
    .n_rst_i             (n_rst_i),
    .valid_i             (valid_i),
    .op_i                (op_i),
    .pc_i                (pc_i),
    .rs1_data_i          (rs1_data_i),
    .rs2_data_i          (rs2_data_i),
    .imm_i               (imm_i),
    .rd_idx_i            (rd_idx_i),
    .rs1_idx_i           (rs1_idx_i),
    .pred_taken_i        (pred_taken_i),
    .pred_next_pc_i      (pred_next_pc_i),
    .stall_i             (stall_i),
    .flush_i             (flush_i),
    .branch_request_o    (branch_request_o),
    .branch_source_o     (branch_source_o),
    .branch_is_taken_o   (branch_is_taken_o),
    .branch_is_call_o    (branch_is_call_o),
    .branch_is_ret_o     (branch_is_ret_o),
    .branch_is_jmp_o     (branch_is_jmp_o),
    .branch_target_o     (branch_target_o),
    .branch_mispredict_o (branch_mispredict_o),
    .redirect_o          (redirect_o),
    .misalign_o          (misalign_o),
    .br_cnt_o            (br_cnt_o),
    .mispred_cnt_o       (mispred_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    valid_i        = 1'b0;
    op_i           = 4'h0;
    pc_i           = '0;
    rs1_data_i     = '0;
    rs2_data_i     = '0;
    imm_i          = '0;
    rd_idx_i       = '0;
    rs1_idx_i      = '0;
    pred_taken_i   = 1'b0;
    pred_next_pc_i = '0;
    stall_i        = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rd,
                        input logic [4:0] rs1i, input logic [31:0] pred);
    op_i           = op;
    pc_i           = pc;
    rs1_data_i     = rs1;
    rs2_data_i     = rs2;
    imm_i          = imm;
    rd_idx_i       = rd;
    rs1_idx_i      = rs1i;
    pred_next_pc_i = pred;
    pred_taken_i   = (pred != pc + 32'd4);
    valid_i        = 1'b1;
  endtask

  // Presents one op for one cycle; returns 1ns after the edge, with its result visible.
  task automatic send(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rd,
                      input logic [4:0] rs1i, input logic [31:0] pred);
    set_op(op, pc, rs1, rs2, imm, rd, rs1i, pred);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req",   branch_request_o, 32'd0);
    chk("rst_redir", redirect_o,       32'd0);
    chk("rst_mis",   misalign_o,       32'd0);
    chk("rst_tgt",   branch_target_o,  32'd0);
    chk("rst_br",    br_cnt_o,         32'd0);
    chk("rst_mp",    mispred_cnt_o,    32'd0);
    n_rst_i = 1'b1;
    @(posedge clk_i); #1;

    send(BR_OP_BEQ, 32'h100, 32'd5, 32'd5, 32'h20, 5'd0, 5'd0, 32'h120);
    chk("t1_req",   branch_request_o,    32'd1);
    chk("t1_taken", branch_is_taken_o,   32'd1);
    chk("t1_tgt",   branch_target_o,     32'h120);
    chk("t1_src",   branch_source_o,     32'h100);
    chk("t1_misp",  branch_mispredict_o, 32'd0);
    chk("t1_redir", redirect_o,          32'd0);
    @(posedge clk_i); #1;
    chk("t1_pulse", branch_request_o,    32'd0);

    send(BR_OP_BLT, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 5'd0, 5'd0, 32'h204);
    chk("t2_taken", branch_is_taken_o,   32'd1);
    chk("t2_tgt",   branch_target_o,     32'h240);
    chk("t2_misp",  branch_mispredict_o, 32'd1);
    chk("t2_redir", redirect_o,          32'd1);
    set_op(BR_OP_BEQ, 32'h500, 32'd0, 32'd0, 32'h8, 5'd0, 5'd0, 32'h508);
    @(posedge clk_i); #1;
    chk("t2_kill1", branch_request_o, 32'd0);
    chk("t2_rdrop", redirect_o,       32'd0);
    @(posedge clk_i); #1;
    chk("t2_kill2", branch_request_o, 32'd0);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("t2_after", branch_request_o, 32'd1);
    chk("t2_asrc",  branch_source_o,  32'h500);

    send(BR_OP_BGEU, 32'h800, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 5'd0, 32'h810);
    chk("bgeu_taken", branch_is_taken_o, 32'd1);
    chk("bgeu_tgt",   branch_target_o,   32'h810);
    set_op(BR_OP_BEQ, 32'h900, 32'd0, 32'd0, 32'h8, 5'd0, 5'd0, 32'h908);
    stall_i = 1'b1;
    @(posedge clk_i); #1;
    chk("stall_req", branch_request_o, 32'd0);
    chk("stall_src", branch_source_o,  32'h800);
    stall_i = 1'b0;
    valid_i = 1'b0;

    send(BR_OP_JAL, 32'h300, 32'd0, 32'd0, 32'h100, 5'd1, 5'd0, 32'h400);
    chk("t3_call",  branch_is_call_o, 32'd1);
    chk("t3_jmp",   branch_is_jmp_o,  32'd0);
    chk("t3_ret",   branch_is_ret_o,  32'd0);
    chk("t3_tgt",   branch_target_o,  32'h400);
    send(BR_OP_JALR, 32'h310, 32'h305, 32'd0, 32'd0, 5'd0, 5'd1, 32'h304);
    chk("t3_rret",  branch_is_ret_o,     32'd1);
    chk("t3_rcall", branch_is_call_o,    32'd0);
    chk("t3_rtgt",  branch_target_o,     32'h304);
    chk("t3_rmisp", branch_mispredict_o, 32'd0);
    send(BR_OP_JAL, 32'h340, 32'd0, 32'd0, 32'h20, 5'd0, 5'd0, 32'h360);
    chk("jal_jmp",  branch_is_jmp_o,  32'd1);
    chk("jal_call", branch_is_call_o, 32'd0);
    send(BR_OP_BLTU, 32'h380, 32'hFFFF_FFFF, 32'd1, 32'h40, 5'd0, 5'd0, 32'h384);
    chk("bltu_taken", branch_is_taken_o,   32'd0);
    chk("bltu_tgt",   branch_target_o,     32'h384);
    chk("bltu_misp",  branch_mispredict_o, 32'd0);
    chk("mid_br", br_cnt_o,      32'd8);
    chk("mid_mp", mispred_cnt_o, 32'd1);

    send(BR_OP_JALR, 32'h3A0, 32'h400, 32'd0, 32'd2, 5'd0, 5'd6, 32'h3A4);
    chk("t4_mis",   misalign_o,       32'd1);
    chk("t4_req",   branch_request_o, 32'd0);
    chk("t4_redir", redirect_o,       32'd0);
    chk("t4_br",    br_cnt_o,         32'd8);
    chk("t4_mp",    mispred_cnt_o,    32'd1);
    @(posedge clk_i); #1;
    chk("t4_pulse", misalign_o,       32'd0);

    send(BR_OP_BNE, 32'h600, 32'd3, 32'd3, 32'h40, 5'd0, 5'd0, 32'h640);
    chk("t5_taken", branch_is_taken_o, 32'd0);
    chk("t5_tgt",   branch_target_o,   32'h604);
    chk("t5_redir", redirect_o,        32'd1);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    send(BR_OP_BEQ, 32'h700, 32'd0, 32'd0, 32'h10, 5'd0, 5'd0, 32'h710);
    chk("t5_req",  branch_request_o, 32'd1);
    chk("t5_src",  branch_source_o,  32'h700);
    set_op(BR_OP_BEQ, 32'h720, 32'd0, 32'd0, 32'h10, 5'd0, 5'd0, 32'h730);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    chk("t5_fvreq", branch_request_o, 32'd0);
    chk("t5_br",    br_cnt_o,         32'd10);
    chk("t5_mp",    mispred_cnt_o,    32'd2);

    send(BR_OP_BLT, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 5'd0, 5'd0, 32'h204);
    chk("t6_redir", redirect_o, 32'd1);
    chk("t6_br",    br_cnt_o,   32'd11);
    #2 n_rst_i = 1'b0;
    #1;
    chk("t6_areq",   branch_request_o, 32'd0);
    chk("t6_aredir", redirect_o,       32'd0);
    chk("t6_atgt",   branch_target_o,  32'd0);
    chk("t6_abr",    br_cnt_o,         32'd0);
    chk("t6_amp",    mispred_cnt_o,    32'd0);
    #2 n_rst_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 10; i++) begin
      logic        mp;
      logic [31:0] pc;
      mp = (i == 2) || (i == 5) || (i == 8);
      pc = 32'h1000 + 32'(i) * 32'h10;
      send(BR_OP_BEQ, pc, 32'd7, 32'd7, 32'h20, 5'd0, 5'd0, mp ? pc + 32'd4 : pc + 32'h20);
      chk("t6_lreq",  branch_request_o,    32'd1);
      chk("t6_lmisp", branch_mispredict_o, {31'd0, mp});
      if (mp) begin
        repeat (2) @(posedge clk_i);
        #1;
      end
    end
    chk("t6_br", br_cnt_o,      32'd10);
    chk("t6_mp", mispred_cnt_o, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
